// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: default 12 MHz timing, GRB pixel layout and receiver states.
package ws2812_pkg;

    localparam int T0H_CYC   = 5;
    localparam int T1H_CYC   = 10;
    localparam int T0L_CYC   = 10;
    localparam int T1L_CYC   = 5;
    localparam int RESET_CYC = 600;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= RST_VAL;
            q       <= RST_VAL;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 line decoder: measures high/low run lengths on the synchronized line,
// assembles 24-bit GRB pixels, numbers them per frame and reports latches and faults.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int MIN_HIGH     = 2,
    parameter int BIT_THRESH   = 8,
    parameter int MAX_HIGH     = 14,
    parameter int RESET_CYCLES = RESET_CYC,
    parameter int NUM_PIXELS   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          din,
    output logic [23:0]                   pixel_grb,
    output logic [$clog2(NUM_PIXELS)-1:0] pixel_idx,
    output logic                          pixel_valid,
    output logic                          frame_done,
    output logic [$clog2(NUM_PIXELS):0]   pixel_count,
    output logic                          overflow,
    output logic                          pulse_err
);

    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam int CNT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [CNT_W-1:0] MIN_L    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] THR_L    = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] RC_L     = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] RC_M1    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [IDX_W:0]   NUM_L    = (IDX_W + 1)'(NUM_PIXELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    logic             lvl;
    rx_state_t        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
    logic             accept, err, latch, sync_done, bit_val;

    grb_t             shift_q;
    logic [4:0]       bit_cnt_q;
    logic [IDX_W:0]   frame_idx_q;
    logic             has_bits_q;

    sync_2ff #(.RST_VAL(1'b0)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (lvl)
    );

    assign cnt_inc = (cnt_q >= RC_L) ? cnt_q : cnt_q + 1'b1;
    assign bit_val = (cnt_q >= THR_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // cnt_q holds the number of cycles of the current level seen before this one;
    // an edge loads 1 so the edge cycle itself is counted.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_inc;
        accept    = 1'b0;
        err       = 1'b0;
        latch     = 1'b0;
        sync_done = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (lvl) begin
                    cnt_n = '0;
                end else if (cnt_q >= RC_M1) begin
                    state_n   = IDLE;
                    sync_done = 1'b1;
                end
            end
            IDLE: begin
                if (lvl) begin
                    state_n = HIGH;
                    cnt_n   = CNT_W'(1);
                end
            end
            HIGH: begin
                if (!lvl) begin
                    cnt_n = CNT_W'(1);
                    if (cnt_q < MIN_L || cnt_q > MAX_L) begin
                        err     = 1'b1;
                        state_n = SYNC;
                    end else begin
                        accept  = 1'b1;
                        state_n = LOW;
                    end
                end else if (cnt_q >= MAX_L) begin
                    err     = 1'b1;
                    state_n = SYNC;
                    cnt_n   = '0;
                end
            end
            LOW: begin
                if (lvl) begin
                    state_n = HIGH;
                    cnt_n   = CNT_W'(1);
                end else if (cnt_q >= RC_M1) begin
                    latch   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = SYNC;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            frame_idx_q <= '0;
            has_bits_q  <= 1'b0;
            pixel_grb   <= '0;
            pixel_idx   <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            pixel_count <= '0;
            overflow    <= 1'b0;
            pulse_err   <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            pulse_err   <= err;

            if (accept) begin
                shift_q    <= {shift_q[22:0], bit_val};
                has_bits_q <= 1'b1;
                if (bit_cnt_q == 5'd23) begin
                    bit_cnt_q   <= '0;
                    pixel_grb   <= {shift_q[22:0], bit_val};
                    pixel_valid <= 1'b1;
                    // Past the end of the frame the index sticks at the last slot.
                    if (frame_idx_q >= NUM_L) begin
                        pixel_idx <= LAST_IDX;
                        overflow  <= 1'b1;
                    end else begin
                        pixel_idx   <= frame_idx_q[IDX_W-1:0];
                        frame_idx_q <= frame_idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end

            if (err) begin
                bit_cnt_q <= '0;
            end

            if (latch) begin
                bit_cnt_q   <= '0;
                frame_idx_q <= '0;
                has_bits_q  <= 1'b0;
                if (has_bits_q) begin
                    frame_done  <= 1'b1;
                    pixel_count <= frame_idx_q;
                end
            end

            // Regaining sync after a fault starts a fresh frame silently.
            if (sync_done) begin
                bit_cnt_q   <= '0;
                frame_idx_q <= '0;
                has_bits_q  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Serial decoder for the WS2812 single-wire LED protocol; the receive end of the LED data line that the display top drives on its LED data pin.
- Recovers 24-bit GRB pixel words, numbers them within a frame, and flags latch/reset gaps and timing faults.
- Uses: loop-back self-check on the board (LED data out wired to a spare input pin) and bench-side frame capture for display tops.
- Runs on the 12 MHz system clock; all timing is in clk cycles.

Parameters:
- MIN_HIGH, 2, shortest legal high pulse in cycles; anything shorter is a glitch/error.
- BIT_THRESH, 8, high-pulse length >= BIT_THRESH decodes as 1, otherwise 0.
- MAX_HIGH, 14, longest legal high pulse in cycles.
- RESET_CYCLES, 600, low time in cycles that marks a latch (50 us at 12 MHz).
- NUM_PIXELS, 64, pixels per frame (8x8 matrix).

Ports:
- clk, in, 1, system clock (12 MHz).
- rst_n, in, 1, asynchronous active-low reset.
- din, in, 1, raw WS2812 data line, asynchronous to clk.
- pixel_grb, out, 24, last decoded pixel, G[23:16] R[15:8] B[7:0], MSB received first.
- pixel_idx, out, $clog2(NUM_PIXELS), index of pixel_grb within the current frame.
- pixel_valid, out, 1, one-cycle strobe: pixel_grb and pixel_idx are new.
- frame_done, out, 1, one-cycle strobe on latch detection after at least one bit in the frame.
- pixel_count, out, $clog2(NUM_PIXELS)+1, pixels received in the frame just latched; valid with frame_done.
- overflow, out, 1, sticky: more than NUM_PIXELS pixels in one frame; cleared only by reset.
- pulse_err, out, 1, one-cycle strobe on an illegal high pulse.

Behaviour:
- Reset values: all outputs 0; internal bit count 0; pixel index 0; FSM in SYNC.
- din passes through a 2-FF synchronizer. All edges and lengths are measured on the synchronized signal, so there is a fixed 2-cycle input latency.
- One saturating counter (width fits RESET_CYCLES) measures the length of the current level.
- SYNC: wait until the line has been low for RESET_CYCLES, then go to IDLE. A rising edge while in SYNC restarts the low count. No data is accepted until synchronized.
- IDLE / LOW: on a rising edge, clear the counter and go to HIGH.
  - In LOW, when the low count reaches RESET_CYCLES: if bits were received this frame, pulse frame_done, drive pixel_count, and zero the pixel index. Then go to IDLE.
- HIGH: on the falling edge, with high length L:
  - L < MIN_HIGH or L > MAX_HIGH: pulse pulse_err, discard the partial pixel (bit count = 0), go to SYNC.
  - Otherwise shift bit (L >= BIT_THRESH) into the LSB of a 24-bit shift register and increment the bit count. Go to LOW.
  - Staying high past MAX_HIGH with no falling edge: pulse pulse_err in the cycle L exceeds MAX_HIGH, then go to SYNC.
- On the 24th bit: the cycle after the falling edge, pixel_grb <= shift register, pixel_idx <= frame index, pixel_valid = 1. Frame index increments; bit count returns to 0.
- Pixel index wrap: once NUM_PIXELS pixels have been received, the next completed pixel sets overflow. That pixel is still reported, with pixel_idx saturated at NUM_PIXELS-1.
- Latch with a partial pixel (bit count 1..23): partial bits are discarded, frame_done still pulses, and pixel_count counts complete pixels only.
- frame_done and pixel_valid never assert in the same cycle.
- Asynchronous reset mid-frame returns to SYNC immediately. Outputs go to 0 and no strobe is generated on release.

Decomposition:
- Package ws2812_pkg holds:
  - default timing constants (T0H/T1H/RESET in cycles at 12 MHz), shared with the transmitter;
  - a typedef grb_t (24-bit packed struct: g, r, b);
  - the FSM state enum (SYNC, IDLE, HIGH, LOW).
- One sub-module, sync_2ff (parameterized reset value 0), for the din synchronizer.

Test Plan:
- Reset, din held low for 600 cycles, then one pixel 0x00FF00 (bit 1 = 10 high/5 low, bit 0 = 5 high/10 low) -> pixel_valid once with pixel_grb=0x00FF00, pixel_idx=0. After a 600-cycle low, frame_done with pixel_count=1.
- Full 64-pixel frame, pixel k = {8'(k),8'(~k),8'(k^8'h5A)} -> 64 valid strobes with idx 0..63, data matching; frame_done with pixel_count=64; overflow=0.
- 65 pixels then latch -> overflow=1 at the 65th pixel, pixel_idx=63 for that pixel, pixel_count=64; overflow stays set through the next frame.
- 1-cycle high glitch mid-pixel, then 20-cycle high pulse -> pulse_err strobe on each; no pixel_valid until 600 cycles low, after which a fresh pixel decodes correctly.
- 12 bits followed by a 600-cycle low -> frame_done with pixel_count=0 and no pixel_valid. rst_n asserted mid-pixel -> all outputs 0 immediately; decode resumes only after the SYNC low period.
- Boundary pulse widths L=7 and L=8 -> decode as 0 and 1 respectively; L=2 and L=14 accepted without pulse_err.
